jtag_master: RTL and testbench

// - Host-side JTAG driver: generates tck/tms/tdi, samples tdo, walks a target TAP through reset, IR or DR scans.
// - Keeps a 4-bit mirror of the target TAP state in the codebase TAP encoding.
// - Encoding: 0 TLR, 1 RTI, 2 SelDR, 3 CapDR, 4 ShDR, 5 Ex1DR, 6 PDR, 7 Ex2DR, 8 UpDR,
//   9 SelIR, 10 CapIR, 11 ShIR, 12 Ex1IR, 13 PIR, 14 Ex2IR, 15 UpIR.
// - Sits between a command source (test sequencer/CPU) and the tap_controller pins.

---
 rtl/jtag_master.sv | 202 ++++++++++++++++++++
 tb/tb_jtag_master.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_master.sv
// rtl/jtag_master.sv - host-side JTAG master driving a target TAP through reset, IR and DR scans
//
// Generates tck/tms/tdi, samples tdo and keeps a 4-bit mirror of the target TAP state
// (0 TLR, 1 RTI, 2 SelDR, 3 CapDR, 4 ShDR, 5 Ex1DR, 6 PDR, 7 Ex2DR, 8 UpDR,
//  9 SelIR, 10 CapIR, 11 ShIR, 12 Ex1IR, 13 PIR, 14 Ex2IR, 15 UpIR).
// Optional feature macro: JTAG_MASTER_RTI_EN adds cmd_rti (extra RTI TCK cycles per command).
//
// Ports:
//   clk                 system clock
//   tap_por             asynchronous active-low reset
//   cmd_valid/ready     command handshake (ready only while idle in RTI)
//   cmd_rst             1 = TAP reset sequence, overrides the scan fields
//   cmd_ir              1 = IR scan, 0 = DR scan
//   cmd_len             scan length in bits, clamped to MAX_LEN
//   cmd_data            TDI bits, LSB shifted first
//   cmd_rti             (JTAG_MASTER_RTI_EN only) extra RTI cycles after the command
//   rsp_valid           one-clk completion pulse
//   rsp_data            captured TDO, first bit at [0], held until the next accept
//   busy                inverse of cmd_ready
//   tck/tms/tdi/tdo     JTAG pins
//   tstate              mirrored TAP state
module jtag_master #(
   parameter int MAX_LEN = 32,
   parameter int DIV     = 2,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               tap_por,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_rst,
   input  logic               cmd_ir,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
`ifdef JTAG_MASTER_RTI_EN
   input  logic [7:0]         cmd_rti,
`endif
   output logic               rsp_valid,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               busy,
   output logic               tck,
   output logic               tms,
   output logic               tdi,
   input  logic               tdo,
   output logic [3:0]         tstate
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW = $clog2(MAX_LEN + 6 + 256);

   localparam logic [3:0] TLR = 4'd0,  RTI = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3;
   localparam logic [3:0] SH_DR = 4'd4, EX1_DR = 4'd5, P_DR = 4'd6, EX2_DR = 4'd7;
   localparam logic [3:0] UP_DR = 4'd8, SEL_IR = 4'd9, CAP_IR = 4'd10, SH_IR = 4'd11;
   localparam logic [3:0] EX1_IR = 4'd12, P_IR = 4'd13, EX2_IR = 4'd14, UP_IR = 4'd15;

   typedef enum logic [1:0] {ST_INIT, ST_READY, ST_RUN, ST_DONE} state_t;

   state_t             state;
   logic [DW-1:0]      div_cnt;
   logic [CW-1:0]      cyc;       // index of the current TCK cycle
   logic [CW-1:0]      tot;       // TCK cycles in the current sequence
   logic               rst_q;     // current sequence is the fixed reset walk
   logic               ir_q;
   logic [LEN_W-1:0]   rem;       // shift bits still to go
   logic [MAX_LEN-1:0] data_q;    // remaining TDI bits, next one at [0]
   logic [MAX_LEN-1:0] bit_mask;  // rsp_data position of the next captured bit

   logic [LEN_W-1:0]   len_c;
   logic [CW-1:0]      rti_ext;
   logic [CW-1:0]      tot_cyc;

`ifdef JTAG_MASTER_RTI_EN
   assign rti_ext = CW'(cmd_rti);
`else
   assign rti_ext = '0;
`endif

   always_comb begin
      len_c   = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
      tot_cyc = (cmd_rst ? CW'(6) : CW'(len_c) + CW'(5) + CW'(cmd_ir)) + rti_ext;
   end

   assign busy = ~cmd_ready;

   function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
      case (s)
         TLR:    tap_next = m ? TLR    : RTI;
         RTI:    tap_next = m ? SEL_DR : RTI;
         SEL_DR: tap_next = m ? SEL_IR : CAP_DR;
         CAP_DR: tap_next = m ? EX1_DR : SH_DR;
         SH_DR:  tap_next = m ? EX1_DR : SH_DR;
         EX1_DR: tap_next = m ? UP_DR  : P_DR;
         P_DR:   tap_next = m ? EX2_DR : P_DR;
         EX2_DR: tap_next = m ? UP_DR  : SH_DR;
         UP_DR:  tap_next = m ? SEL_DR : RTI;
         SEL_IR: tap_next = m ? TLR    : CAP_IR;
         CAP_IR: tap_next = m ? EX1_IR : SH_IR;
         SH_IR:  tap_next = m ? EX1_IR : SH_IR;
         EX1_IR: tap_next = m ? UP_IR  : P_IR;
         P_IR:   tap_next = m ? EX2_IR : P_IR;
         EX2_IR: tap_next = m ? UP_IR  : SH_IR;
         default: tap_next = m ? SEL_DR : RTI;
      endcase
   endfunction

   function automatic logic is_shift(input logic [3:0] s);
      is_shift = (s == SH_DR) || (s == SH_IR);
   endfunction

   // TMS for the TCK cycle spent in state s (scans only). RTI here means the
   // scan is complete, so any remaining cycles idle there.
   function automatic logic scan_tms(input logic [3:0] s, input logic ir, input logic [LEN_W-1:0] r);
      case (s)
         SEL_DR:                 scan_tms = ir;
         CAP_DR, CAP_IR:         scan_tms = (r == '0);
         SH_DR, SH_IR:           scan_tms = (r == LEN_W'(1));
         EX1_DR, EX1_IR, P_DR,
         P_IR, EX2_DR, EX2_IR:   scan_tms = 1'b1;
         default:                scan_tms = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge tap_por) begin
      if (!tap_por) begin
         state     <= ST_INIT;
         tck       <= 1'b0;
         tms       <= 1'b1;
         tdi       <= 1'b0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         tstate    <= TLR;
         div_cnt   <= '0;
         cyc       <= '0;
         tot       <= CW'(6);
         rst_q     <= 1'b1;
         ir_q      <= 1'b0;
         rem       <= '0;
         data_q    <= '0;
         bit_mask  <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_READY, ST_DONE: begin
               state <= ST_READY;
               if (cmd_valid) begin
                  // The accept edge is also the start of the first TCK cycle.
                  state     <= ST_RUN;
                  cmd_ready <= 1'b0;
                  rsp_data  <= '0;
                  div_cnt   <= '0;
                  cyc       <= '0;
                  tot       <= tot_cyc;
                  rst_q     <= cmd_rst;
                  ir_q      <= cmd_ir;
                  rem       <= cmd_rst ? '0 : len_c;
                  data_q    <= cmd_data;
                  bit_mask  <= MAX_LEN'(1);
                  tms       <= 1'b1;
                  tdi       <= 1'b0;
               end
            end
            default: begin
               if (div_cnt != DW'(DIV - 1)) begin
                  div_cnt <= div_cnt + 1'b1;
               end else begin
                  div_cnt <= '0;
                  if (!tck) begin
                     tck    <= 1'b1;
                     tstate <= tap_next(tstate, tms);
                     if (is_shift(tstate)) begin
                        if (tdo) rsp_data <= rsp_data | bit_mask;
                        bit_mask <= bit_mask << 1;
                        data_q   <= data_q >> 1;
                        rem      <= rem - 1'b1;
                     end
                  end else begin
                     tck <= 1'b0;
                     if (cyc == tot - 1'b1) begin
                        tms       <= 1'b0;
                        tdi       <= 1'b0;
                        cyc       <= '0;
                        cmd_ready <= 1'b1;
                        if (state == ST_RUN) begin
                           state     <= ST_DONE;
                           rsp_valid <= 1'b1;
                        end else begin
                           state <= ST_READY;
                        end
                     end else begin
                        cyc <= cyc + 1'b1;
                        tms <= rst_q ? (cyc + 1'b1 < CW'(5)) : scan_tms(tstate, ir_q, rem);
                        tdi <= is_shift(tstate) ? data_q[0] : 1'b0;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_master.sv
// tb/tb_jtag_master.sv - self-checking bench for jtag_master against a behavioural target TAP
module tb_jtag_master;
   localparam int MAX_LEN = 32;
   localparam int DIV     = 2;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);

   logic               clk = 1'b0;
   logic               tap_por;
   logic               cmd_valid = 1'b0;
   logic               cmd_ready;
   logic               cmd_rst = 1'b0;
   logic               cmd_ir = 1'b0;
   logic [LEN_W-1:0]   cmd_len = '0;
   logic [MAX_LEN-1:0] cmd_data = '0;
`ifdef JTAG_MASTER_RTI_EN
   logic [7:0]         cmd_rti = '0;
   localparam int      RTI_MAX = 3;
`else
   localparam int      RTI_MAX = 0;
`endif
   logic               rsp_valid;
   logic [MAX_LEN-1:0] rsp_data;
   logic               busy, tck, tms, tdi, tdo;
   logic [3:0]         tstate;

   always #5 clk = ~clk;

   jtag_master #(.MAX_LEN(MAX_LEN), .DIV(DIV)) dut (
      .clk(clk), .tap_por(tap_por), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_rst(cmd_rst), .cmd_ir(cmd_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
`ifdef JTAG_MASTER_RTI_EN
      .cmd_rti(cmd_rti),
`endif
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .tck(tck), .tms(tms),
      .tdi(tdi), .tdo(tdo), .tstate(tstate)
   );

   // Behavioural target TAP: transition tables, capture/shift registers, logs.
   logic [3:0]  nx0 [16];
   logic [3:0]  nx1 [16];
   logic [3:0]  tgt_state;
   logic [31:0] tgt_sr, tgt_in, tgt_ir, dr_cap, ir_cap;
   int          tgt_n, nrise;
   bit          tms_q[$];
   bit          rx_q[$];

   assign tdo = tgt_sr[0];

   always @(posedge tck or negedge tap_por) begin
      if (!tap_por) begin
         tgt_state <= 4'd0;
         tgt_sr    <= '0;
      end else begin
         tms_q.push_back(tms);
         nrise <= nrise + 1;
         case (tgt_state)
            4'd3:  begin tgt_sr <= dr_cap; tgt_in <= '0; tgt_n <= 0; end
            4'd10: begin tgt_sr <= ir_cap; tgt_in <= '0; tgt_n <= 0; end
            4'd4, 4'd11: begin
               tgt_sr <= {tdi, tgt_sr[31:1]};
               tgt_in <= {tdi, tgt_in[31:1]};
               tgt_n  <= tgt_n + 1;
               rx_q.push_back(tdi);
            end
            4'd15: tgt_ir <= tgt_in >> (32 - tgt_n);
            default: ;
         endcase
         tgt_state <= tms ? nx1[tgt_state] : nx0[tgt_state];
      end
   end

   int neg_n = 0, rv_total = 0, st_err = 0, tdi_err = 0;
   always @(negedge clk) begin
      neg_n <= neg_n + 1;
      if (rsp_valid === 1'b1) rv_total <= rv_total + 1;
      if (tap_por && tstate !== tgt_state) st_err <= st_err + 1;
      if (tap_por && !tck && !(tgt_state == 4'd4 || tgt_state == 4'd11) && tdi !== 1'b0)
         tdi_err <= tdi_err + 1;
   end

   int tests = 0, fails = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Count of positions where the logged TMS differs from the expected walk.
   function automatic int tms_diff(input int t0, input bit eq[$]);
      int mm = 0;
      if (tms_q.size() - t0 != eq.size()) mm++;
      for (int i = 0; i < eq.size(); i++)
         if (t0 + i >= tms_q.size() || tms_q[t0 + i] != eq[i]) mm++;
      return mm;
   endfunction

   task automatic run_cmd(input string nm, input bit r, input bit ir, input int len,
                          input logic [31:0] data, input logic [31:0] cap, input int rti);
      int          lc, n, k, m, r0, rx0, t0, st0, td0, nrx;
      bit          got;
      bit          eq[$];
      logic [63:0] msk, rxv;
      for (int i = 0; i < 400 && cmd_ready !== 1'b1; i++) @(negedge clk);
      chk({nm, " ready"}, 64'(cmd_ready), 64'd1);
      lc  = r ? 0 : (len > MAX_LEN ? MAX_LEN : len);
      n   = (r ? 6 : lc + 5 + int'(ir)) + rti;
      msk = (64'd1 << lc) - 64'd1;
      // Reference TMS walk from RTI back to RTI.
      if (r) eq = '{1, 1, 1, 1, 1, 0};
      else begin
         eq.push_back(1);
         if (ir) eq.push_back(1);
         eq.push_back(0);
         if (lc == 0) eq.push_back(1);
         else begin
            eq.push_back(0);
            for (int i = 0; i < lc - 1; i++) eq.push_back(0);
            eq.push_back(1);
         end
         eq.push_back(1);
         eq.push_back(0);
      end
      for (int i = 0; i < rti; i++) eq.push_back(0);

      dr_cap = cap; ir_cap = cap;
      cmd_rst = r; cmd_ir = ir; cmd_len = LEN_W'(len); cmd_data = data;
`ifdef JTAG_MASTER_RTI_EN
      cmd_rti = 8'(rti);
`endif
      cmd_valid = 1'b1;
      k = neg_n; r0 = nrise; rx0 = rx_q.size(); t0 = tms_q.size(); st0 = st_err; td0 = tdi_err;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_rst = 1'($urandom); cmd_ir = 1'($urandom); cmd_len = LEN_W'($urandom); cmd_data = $urandom;
      got = 1'b0;
      for (int i = 0; i < n * 2 * DIV + 40; i++) begin
         if (rsp_valid === 1'b1) begin got = 1'b1; break; end
         if (i == 3) begin
            chk({nm, " busy"}, 64'(busy), 64'd1);
            cmd_valid = 1'b1;
         end
         if (i == 6) cmd_valid = 1'b0;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      m = neg_n;
      chk({nm, " latency"}, got ? 64'(m - k) : 64'd0, 64'(n * 2 * DIV + 1));
      chk({nm, " rsp_data"}, 64'(rsp_data), {32'd0, cap} & msk);
      chk({nm, " tck cycles"}, 64'(nrise - r0), 64'(n));
      nrx = rx_q.size() - rx0;
      rxv = '0;
      for (int i = 0; i < nrx && i < 64; i++) rxv[i] = rx_q[rx0 + i];
      chk({nm, " shift count"}, 64'(nrx), 64'(lc));
      chk({nm, " tdi bits"}, rxv, {32'd0, data} & msk);
      chk({nm, " tms walk"}, 64'(tms_diff(t0, eq)), 64'd0);
      chk({nm, " tstate end"}, 64'(tstate), 64'd1);
      chk({nm, " mirror"}, 64'(st_err - st0), 64'd0);
      chk({nm, " tdi idle"}, 64'(tdi_err - td0), 64'd0);
   endtask

   task automatic por_release(input string nm);
      int  k, t0, rv0;
      bit  got;
      bit  eq[$];
      eq = '{1, 1, 1, 1, 1, 0};
      rv0 = rv_total;
      t0 = tms_q.size();
      tap_por = 1'b1;
      k = neg_n;
      got = 1'b0;
      for (int i = 0; i < 12 * DIV + 40; i++) begin
         if (cmd_ready === 1'b1) begin got = 1'b1; break; end
         @(negedge clk);
      end
      chk({nm, " ready latency"}, got ? 64'(neg_n - k) : 64'd0, 64'(12 * DIV));
      chk({nm, " init tms"}, 64'(tms_diff(t0, eq)), 64'd0);
      chk({nm, " init tstate"}, 64'(tstate), 64'd1);
      repeat (2) @(negedge clk);
      chk({nm, " no rsp_valid"}, 64'(rv_total - rv0), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rx0, rv0;
      nx0 = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
      nx1 = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
      tap_por = 1'b1;
      #2 tap_por = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst tck", 64'(tck), 64'd0);
      chk("rst tms", 64'(tms), 64'd1);
      chk("rst tdi", 64'(tdi), 64'd0);
      chk("rst cmd_ready", 64'(cmd_ready), 64'd0);
      chk("rst busy", 64'(busy), 64'd1);
      chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst rsp_data", 64'(rsp_data), 64'd0);
      chk("rst tstate", 64'(tstate), 64'd0);
      @(negedge clk);
      por_release("por");

      run_cmd("dr8", 1'b0, 1'b0, 8, 32'hA5, 32'h3C, 0);
      @(negedge clk);
      chk("dr8 pulse width", 64'(rsp_valid), 64'd0);
      chk("dr8 rsp held", 64'(rsp_data), 64'h3C);
      run_cmd("ir4", 1'b0, 1'b1, 4, 32'h2, 32'h1, 0);
      chk("ir4 target ir", 64'(tgt_ir), 64'h2);
      run_cmd("dr0", 1'b0, 1'b0, 0, 32'hFFFF_FFFF, 32'h5, 0);
      run_cmd("dr40", 1'b0, 1'b0, 40, $urandom, $urandom, 0);
      run_cmd("tap reset", 1'b1, 1'b0, 12, $urandom, $urandom, 0);
      run_cmd("ir32", 1'b0, 1'b1, 32, $urandom, $urandom, 0);

      for (int c = 0; c < 24; c++) begin
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         run_cmd($sformatf("rnd%0d", c), $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 40), $urandom, $urandom, $urandom_range(0, RTI_MAX));
      end

      // Drop reset in the middle of a shift.
      dr_cap = $urandom;
      cmd_rst = 1'b0; cmd_ir = 1'b0; cmd_len = LEN_W'(20); cmd_data = $urandom;
      rx0 = rx_q.size();
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 200 && rx_q.size() < rx0 + 2; i++) @(negedge clk);
      chk("por shift reached", 64'(rx_q.size() - rx0), 64'd2);
      rv0 = rv_total;
      tap_por = 1'b0;
      #1;
      chk("por tck", 64'(tck), 64'd0);
      chk("por tms", 64'(tms), 64'd1);
      chk("por cmd_ready", 64'(cmd_ready), 64'd0);
      chk("por tstate", 64'(tstate), 64'd0);
      repeat (5) @(negedge clk);
      chk("por rsp_valid", 64'(rv_total - rv0), 64'd0);
      por_release("por2");
      run_cmd("after por", 1'b0, 1'b0, 13, $urandom, $urandom, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
